// File: rtl/seq_alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU.
package seq_alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD  = 4'd0;
    localparam op_t OP_SUB  = 4'd1;
    localparam op_t OP_MUL  = 4'd2;
    localparam op_t OP_DIV  = 4'd3;
    localparam op_t OP_AND  = 4'd4;
    localparam op_t OP_OR   = 4'd5;
    localparam op_t OP_NAND = 4'd6;
    localparam op_t OP_NOR  = 4'd7;
    localparam op_t OP_XOR  = 4'd8;
    localparam op_t OP_XNOR = 4'd9;
    localparam op_t OP_EQ   = 4'd10;
    localparam op_t OP_GT   = 4'd11;
    localparam op_t OP_LT   = 4'd12;
    localparam op_t OP_SHR  = 4'd13;
    localparam op_t OP_SHL  = 4'd14;
    localparam op_t OP_NOP  = 4'd15;

    typedef logic [0:0] state_t;

    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_DIV  = 1'b1;

    // Flag vector order: {Arith, Logic, CMP, Shift}
    localparam logic [3:0] FL_NONE  = 4'b0000;
    localparam logic [3:0] FL_ARITH = 4'b1000;
    localparam logic [3:0] FL_LOGIC = 4'b0100;
    localparam logic [3:0] FL_CMP   = 4'b0010;
    localparam logic [3:0] FL_SHIFT = 4'b0001;

endpackage

// File: rtl/seq_alu_div.sv
// Restoring divider: start loads operands, WIDTH iterations follow.
module seq_alu_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_run;

    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_dif;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    assign w_sh       = {r_rem, r_quot[WIDTH-1]};
    assign w_dif      = w_sh - {1'b0, r_div};
    assign w_ge       = ~w_dif[WIDTH];
    assign w_rem_nxt  = w_ge ? w_dif[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

    // Quotient is handed out combinationally during the final iteration
    assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_quot = w_quot_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quot <= i_a;
            r_div  <= i_b;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU, latency 1 except multi-cycle divide.
// Divider is compiled in only when SEQ_ALU_DIV_EN is defined.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    input  logic             Enable,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag,
    output logic             CARRY
);

    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;
    logic             r_carry;
    logic             r_valid;

    op_t              w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;
    logic             w_carry;
    logic             w_acc;
    logic             w_busy;
    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quot;

    assign w_op  = ALU_FUN;
    assign w_sum = {1'b0, A} + {1'b0, B};
    assign w_dif = {1'b0, A} - {1'b0, B};
    assign w_acc = Enable && !w_busy;

    always_comb begin
        w_res   = '0;
        w_flags = FL_NONE;
        w_carry = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_flags = FL_ARITH;
            end
            OP_SUB: begin
                w_res   = w_dif[WIDTH-1:0];
                w_carry = w_dif[WIDTH];
                w_flags = FL_ARITH;
            end
            OP_MUL: begin
                w_res   = A * B;
                w_flags = FL_ARITH;
            end
            OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                // Only reaches the output for B==0
                w_res   = '1;
`endif
                w_flags = FL_ARITH;
            end
            OP_AND:  begin w_res = A & B;    w_flags = FL_LOGIC; end
            OP_OR:   begin w_res = A | B;    w_flags = FL_LOGIC; end
            OP_NAND: begin w_res = ~(A & B); w_flags = FL_LOGIC; end
            OP_NOR:  begin w_res = ~(A | B); w_flags = FL_LOGIC; end
            OP_XOR:  begin w_res = A ^ B;    w_flags = FL_LOGIC; end
            OP_XNOR: begin w_res = ~(A ^ B); w_flags = FL_LOGIC; end
            OP_EQ: begin
                w_res   = {{(WIDTH-1){1'b0}}, A == B};
                w_flags = FL_CMP;
            end
            OP_GT: begin
                w_res   = {{(WIDTH-1){1'b0}}, A > B};
                w_flags = FL_CMP;
            end
            OP_LT: begin
                w_res   = {{(WIDTH-1){1'b0}}, A < B};
                w_flags = FL_CMP;
            end
            OP_SHR:  begin w_res = A >> 1;   w_flags = FL_SHIFT; end
            OP_SHL:  begin w_res = A << 1;   w_flags = FL_SHIFT; end
            default: ;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    state_t r_state;

    assign w_busy      = (r_state == S_DIV);
    assign w_div_start = w_acc && (w_op == OP_DIV) && (B != '0);

    seq_alu_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_a     (A),
        .i_b     (B),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (w_div_start) begin
            r_state <= S_DIV;
        end else if (w_div_done) begin
            r_state <= S_IDLE;
        end
    end
`else
    assign w_busy      = 1'b0;
    assign w_div_start = 1'b0;
    assign w_div_done  = 1'b0;
    assign w_quot      = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_flags <= FL_NONE;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_div_done) begin
                r_out   <= w_quot;
                r_flags <= FL_ARITH;
                r_carry <= 1'b0;
                r_valid <= 1'b1;
            end else if (w_acc && !w_div_start) begin
                r_out   <= w_res;
                r_flags <= w_flags;
                r_carry <= w_carry;
                r_valid <= 1'b1;
            end
        end
    end

    assign ALU_OUT    = r_out;
    assign OUT_VALID  = r_valid;
    assign BUSY       = w_busy;
    assign Arith_Flag = r_flags[3];
    assign Logic_Flag = r_flags[2];
    assign CMP_Flag   = r_flags[1];
    assign Shift_Flag = r_flags[0];
    assign CARRY      = r_carry;

endmodule
